// File: rtl/vector_ops_pkg.sv
// Shared types and width-generic bit-manipulation helpers for the vector_ops pipeline.
// Each helper works on a MAX_W container; only the low w bits are meaningful.
package vector_ops_pkg;

  localparam int MAX_W = 64;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_ROTL  = 2'b01,
    MODE_ROTR  = 2'b10,
    MODE_HSWAP = 2'b11
  } mode_e;

  typedef logic [MAX_W-1:0] word_t;

  // Rotate the low w bits left by amt, modulo w.
  function automatic word_t rotl(input word_t v, input int unsigned amt, input int unsigned w);
    word_t       r;
    int unsigned a;
    int unsigned j;
    r = '0;
    a = amt % w;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        j = i + a;
        if (j >= w) j = j - w;
        r[j[5:0]] = v[i[5:0]];
      end
    end
    return r;
  endfunction

  function automatic word_t rotr(input word_t v, input int unsigned amt, input int unsigned w);
    return rotl(v, w - (amt % w), w);
  endfunction

  function automatic word_t bit_rev(input word_t v, input int unsigned w);
    word_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        j = w - 1 - i;
        r[j[5:0]] = v[i[5:0]];
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input word_t v, input int unsigned w);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) c = c + CNT_W'(v[i[5:0]]);
    end
    return c;
  endfunction

endpackage

// File: rtl/vector_ops_if.sv
// Upstream/downstream handshake bundle for vector_ops_pipe.
// The DUT side takes the slave modport; a driver or bench takes master.
interface vector_ops_if #(
  parameter int DATA_W = 8,
  parameter int ROT_W  = $clog2(DATA_W),
  parameter int ACC_W  = 16
) ();

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_mode;
  logic [ROT_W-1:0]    in_rot;
  logic                out_valid;
  logic                out_ready;
  logic                out_parity;
  logic [DATA_W/2-1:0] out_hi;
  logic [DATA_W-1:0]   out_rev;
  logic [DATA_W-1:0]   out_xform;
  logic                clr_acc;
  logic [ACC_W-1:0]    out_acc;

  modport slave (
    input  in_valid, in_data, in_mode, in_rot, out_ready, clr_acc,
    output in_ready, out_valid, out_parity, out_hi, out_rev, out_xform, out_acc
  );

  modport master (
    output in_valid, in_data, in_mode, in_rot, out_ready, clr_acc,
    input  in_ready, out_valid, out_parity, out_hi, out_rev, out_xform, out_acc
  );

endinterface

// File: rtl/vector_ops_stage.sv
// Generic valid/ready register slice: holds one payload, accepts a new one whenever
// it is empty or its current payload is leaving this cycle.
module vector_ops_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign w_load  = !r_valid || i_ready;
  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // NOTE: non-blocking assignments so chained stages all see pre-edge values; the
  // payload is reset as well because the block's data outputs must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/vector_ops_pipe.sv
// Two-stage vector manipulation pipeline: S1 captures the request, the transform is
// computed from S1 and registered into S2, and delivered beats feed a saturating popcount.
module vector_ops_pipe
  import vector_ops_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROT_W  = $clog2(DATA_W),
  parameter int ACC_W  = 16
) (
  input logic          clk,
  input logic          rst,
  vector_ops_if.slave  bus
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PC_W   = $clog2(DATA_W + 1);
  localparam int SUM_W  = ((ACC_W > PC_W) ? ACC_W : PC_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  typedef struct packed {
    logic [DATA_W-1:0] data;
    mode_e             mode;
    logic [ROT_W-1:0]  rot;
  } s1_t;

  typedef struct packed {
    logic              parity;
    logic [HALF_W-1:0] hi;
    logic [DATA_W-1:0] rev;
    logic [DATA_W-1:0] xform;
    logic [PC_W-1:0]   pc;
  } s2_t;

  s1_t  w_s1_in, w_s1_q;
  s2_t  w_s2_in, w_s2_q;
  logic w_s1_valid, w_s1_ready;
  logic w_s2_valid, w_s2_ready;

  assign w_s1_in.data = bus.in_data;
  assign w_s1_in.mode = mode_e'(bus.in_mode);
  assign w_s1_in.rot  = bus.in_rot;

  vector_ops_stage #(.W($bits(s1_t))) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.in_valid),
    .o_ready (w_s1_ready),
    .i_data  (w_s1_in),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_q)
  );

  assign bus.in_ready = !rst && w_s1_ready;

  word_t            w_word, w_rotl, w_rotr, w_rev;
  logic [CNT_W-1:0] w_pc;

  always_comb begin
    w_word = word_t'(w_s1_q.data);
    w_rotl = rotl(w_word, 32'(w_s1_q.rot), DATA_W);
    w_rotr = rotr(w_word, 32'(w_s1_q.rot), DATA_W);
    w_rev  = bit_rev(w_word, DATA_W);
    w_pc   = popcount(w_word, DATA_W);

    w_s2_in        = '0;
    w_s2_in.parity = ^w_s1_q.data;
    w_s2_in.hi     = w_s1_q.data[DATA_W-1:HALF_W];
    w_s2_in.rev    = w_rev[DATA_W-1:0];
    w_s2_in.pc     = w_pc[PC_W-1:0];
    case (w_s1_q.mode)
      MODE_ROTL:  w_s2_in.xform = w_rotl[DATA_W-1:0];
      MODE_ROTR:  w_s2_in.xform = w_rotr[DATA_W-1:0];
      MODE_HSWAP: w_s2_in.xform = {w_s1_q.data[HALF_W-1:0], w_s1_q.data[DATA_W-1:HALF_W]};
      default:    w_s2_in.xform = w_s1_q.data;
    endcase
  end

  vector_ops_stage #(.W($bits(s2_t))) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_in),
    .o_valid (w_s2_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_s2_q)
  );

  assign bus.out_valid  = w_s2_valid;
  assign bus.out_parity = w_s2_q.parity;
  assign bus.out_hi     = w_s2_q.hi;
  assign bus.out_rev    = w_s2_q.rev;
  assign bus.out_xform  = w_s2_q.xform;

  // A clear coinciding with a delivery restarts the count from that beat's popcount.
  logic             w_out_xfer;
  logic [ACC_W-1:0] w_acc_base, w_acc_next;
  logic [SUM_W-1:0] w_sum;
  logic [ACC_W-1:0] r_acc;

  assign w_out_xfer = w_s2_valid && bus.out_ready;

  always_comb begin
    w_acc_base = bus.clr_acc ? '0 : r_acc;
    w_sum      = SUM_W'(w_acc_base) + SUM_W'(w_s2_q.pc);
    w_acc_next = (w_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : w_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_out_xfer) begin
      r_acc <= w_acc_next;
    end else if (bus.clr_acc) begin
      r_acc <= '0;
    end
  end

  assign bus.out_acc = r_acc;

endmodule

// File: tb/tb_vector_ops_pipe.sv
// Scoreboard bench for vector_ops_pipe: three instances (8-bit, 8-bit with 4-bit
// accumulator, 16-bit) driven with directed vectors whose results are worked out by hand.
module tb_vector_ops_pipe;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  always #5 clk = ~clk;

  vector_ops_if #(.DATA_W(8),  .ACC_W(16)) ifa ();
  vector_ops_if #(.DATA_W(8),  .ACC_W(4))  ifb ();
  vector_ops_if #(.DATA_W(16), .ACC_W(16)) ifc ();

  vector_ops_pipe #(.DATA_W(8),  .ACC_W(16)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  vector_ops_pipe #(.DATA_W(8),  .ACC_W(4))  dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
  vector_ops_pipe #(.DATA_W(16), .ACC_W(16)) dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

  typedef struct {
    logic        parity;
    logic [15:0] hi;
    logic [15:0] rev;
    logic [15:0] xform;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_beat(input string tag, input exp_t e, input logic p,
                          input logic [15:0] hi, input logic [15:0] rev, input logic [15:0] xf);
    check({tag, "_parity"}, 32'(p),   32'(e.parity));
    check({tag, "_hi"},     32'(hi),  32'(e.hi));
    check({tag, "_rev"},    32'(rev), 32'(e.rev));
    check({tag, "_xform"},  32'(xf),  32'(e.xform));
  endtask

  // Monitors: sample on the falling edge, pop on every beat that will transfer.
  logic       a_hold = 1'b0;
  logic [7:0] a_held_xf, a_held_rev;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_a) begin
      a_hold <= 1'b0;
    end else begin
      if (a_hold && ifa.out_valid) begin
        check("a_stable_xform", 32'(ifa.out_xform), 32'(a_held_xf));
        check("a_stable_rev",   32'(ifa.out_rev),   32'(a_held_rev));
      end
      a_hold     <= ifa.out_valid && !ifa.out_ready;
      a_held_xf  <= ifa.out_xform;
      a_held_rev <= ifa.out_rev;
      if (ifa.out_valid && ifa.out_ready) begin
        if (q_a.size() == 0) check("a_unexpected_beat", 32'(q_a.size()), 32'd1);
        else begin
          e = q_a.pop_front();
          cmp_beat("a", e, ifa.out_parity, 16'(ifa.out_hi), 16'(ifa.out_rev), 16'(ifa.out_xform));
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst_b && ifb.out_valid && ifb.out_ready) begin
      if (q_b.size() == 0) check("b_unexpected_beat", 32'(q_b.size()), 32'd1);
      else begin
        e = q_b.pop_front();
        cmp_beat("b", e, ifb.out_parity, 16'(ifb.out_hi), 16'(ifb.out_rev), 16'(ifb.out_xform));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (!rst_c && ifc.out_valid && ifc.out_ready) begin
      if (q_c.size() == 0) check("c_unexpected_beat", 32'(q_c.size()), 32'd1);
      else begin
        e = q_c.pop_front();
        cmp_beat("c", e, ifc.out_parity, 16'(ifc.out_hi), ifc.out_rev, ifc.out_xform);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic [1:0] m, input logic [2:0] r, input exp_t e);
    int waited = 0;
    ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_mode = m; ifa.in_rot = r;
    do begin @(negedge clk); waited++; end while (!ifa.in_ready && waited < 50);
    if (!ifa.in_ready) check("a_in_ready_wait", 32'(ifa.in_ready), 32'd1);
    else q_a.push_back(e);
    sync();
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic [1:0] m, input logic [2:0] r, input exp_t e);
    int waited = 0;
    ifb.in_valid = 1'b1; ifb.in_data = d; ifb.in_mode = m; ifb.in_rot = r;
    do begin @(negedge clk); waited++; end while (!ifb.in_ready && waited < 50);
    if (!ifb.in_ready) check("b_in_ready_wait", 32'(ifb.in_ready), 32'd1);
    else q_b.push_back(e);
    sync();
    ifb.in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [15:0] d, input logic [1:0] m, input logic [3:0] r, input exp_t e);
    int waited = 0;
    ifc.in_valid = 1'b1; ifc.in_data = d; ifc.in_mode = m; ifc.in_rot = r;
    do begin @(negedge clk); waited++; end while (!ifc.in_ready && waited < 50);
    if (!ifc.in_ready) check("c_in_ready_wait", 32'(ifc.in_ready), 32'd1);
    else q_c.push_back(e);
    sync();
    ifc.in_valid = 1'b0;
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  // Wait for the scoreboard to empty, then let the last delivery reach the accumulator.
  task automatic drain(input int which, input string tag);
    int n = 0;
    while (qsize(which) != 0 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_drain"}, 32'(qsize(which)), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_mode = '0; ifa.in_rot = '0;
    ifa.out_ready = 1'b1; ifa.clr_acc = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_mode = '0; ifb.in_rot = '0;
    ifb.out_ready = 1'b1; ifb.clr_acc = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_mode = '0; ifc.in_rot = '0;
    ifc.out_ready = 1'b1; ifc.clr_acc = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(ifa.in_ready),  32'd0);
    check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_out_acc",   32'(ifa.out_acc),   32'd0);
    check("rst_out_xform", 32'(ifa.out_xform), 32'd0);
    check("rst_out_rev",   32'(ifa.out_rev),   32'd0);
    sync();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(ifa.in_ready), 32'd1);

    // Pass mode and two-cycle latency
    sync();
    send_a(8'hB4, 2'b00, 3'd0, exp_t'{1'b0, 16'hB, 16'h2D, 16'hB4});
    @(negedge clk);
    check("lat_not_yet", 32'(ifa.out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(ifa.out_valid), 32'd1);
    drain(0, "t1");
    check("t1_acc", 32'(ifa.out_acc), 32'd4);

    // Each transform, back to back, including rot=0 and rotr by DATA_W-1
    sync();
    send_a(8'h81, 2'b01, 3'd3, exp_t'{1'b0, 16'h8, 16'h81, 16'h0C});
    send_a(8'h01, 2'b10, 3'd1, exp_t'{1'b1, 16'h0, 16'h80, 16'h80});
    send_a(8'hA5, 2'b11, 3'd5, exp_t'{1'b0, 16'hA, 16'hA5, 16'h5A});
    send_a(8'h3C, 2'b01, 3'd0, exp_t'{1'b0, 16'h3, 16'h3C, 16'h3C});
    send_a(8'h01, 2'b10, 3'd7, exp_t'{1'b1, 16'h0, 16'h80, 16'h02});
    drain(0, "t2");
    check("t2_acc", 32'(ifa.out_acc), 32'd16);

    // Clear with no transfer
    sync();
    ifa.clr_acc = 1'b1;
    sync();
    ifa.clr_acc = 1'b0;
    @(negedge clk);
    check("clr_alone_acc", 32'(ifa.out_acc), 32'd0);

    // Backpressure stream of five words
    sync();
    ifa.out_ready = 1'b0;
    fork
      begin
        send_a(8'h12, 2'b00, 3'd0, exp_t'{1'b0, 16'h1, 16'h48, 16'h12});
        send_a(8'hF0, 2'b01, 3'd4, exp_t'{1'b0, 16'hF, 16'h0F, 16'h0F});
        send_a(8'h07, 2'b10, 3'd2, exp_t'{1'b1, 16'h0, 16'hE0, 16'hC1});
        send_a(8'hC3, 2'b11, 3'd0, exp_t'{1'b0, 16'hC, 16'hC3, 16'h3C});
        send_a(8'h01, 2'b00, 3'd0, exp_t'{1'b1, 16'h0, 16'h80, 16'h01});
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", 32'(ifa.in_ready),  32'd0);
        check("bp_out_valid",    32'(ifa.out_valid), 32'd1);
        sync();
        ifa.out_ready = 1'b1;
      end
    join
    drain(0, "t3");
    check("t3_acc", 32'(ifa.out_acc), 32'd14);

    // Reset with both stages full
    sync();
    ifa.out_ready = 1'b0;
    send_a(8'hFF, 2'b00, 3'd0, exp_t'{1'b0, 16'hF, 16'hFF, 16'hFF});
    send_a(8'hFF, 2'b00, 3'd0, exp_t'{1'b0, 16'hF, 16'hFF, 16'hFF});
    @(negedge clk);
    check("full_in_ready", 32'(ifa.in_ready), 32'd0);
    sync();
    rst_a = 1'b1;
    q_a.delete();
    @(negedge clk);
    check("midrst_in_ready", 32'(ifa.in_ready), 32'd0);
    @(negedge clk);
    check("midrst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("midrst_out_acc",   32'(ifa.out_acc),   32'd0);
    sync();
    rst_a = 1'b0;
    ifa.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_after", 32'(ifa.in_ready), 32'd1);
    sync();
    send_a(8'h5A, 2'b01, 3'd1, exp_t'{1'b0, 16'h5, 16'h5A, 16'hB4});
    drain(0, "t5");
    check("t5_acc", 32'(ifa.out_acc), 32'd4);

    // Saturation on a 4-bit accumulator, then clear together with a transfer
    sync();
    send_b(8'hFF, 2'b00, 3'd0, exp_t'{1'b0, 16'hF, 16'hFF, 16'hFF});
    send_b(8'hFF, 2'b00, 3'd0, exp_t'{1'b0, 16'hF, 16'hFF, 16'hFF});
    send_b(8'hFF, 2'b00, 3'd0, exp_t'{1'b0, 16'hF, 16'hFF, 16'hFF});
    drain(1, "t4");
    check("t4_acc_sat", 32'(ifb.out_acc), 32'd15);
    sync();
    ifb.out_ready = 1'b0;
    send_b(8'h03, 2'b00, 3'd0, exp_t'{1'b0, 16'h0, 16'hC0, 16'h03});
    for (int i = 0; i < 20 && !ifb.out_valid; i++) @(negedge clk);
    check("t4_out_valid", 32'(ifb.out_valid), 32'd1);
    sync();
    ifb.clr_acc   = 1'b1;
    ifb.out_ready = 1'b1;
    sync();
    ifb.clr_acc = 1'b0;
    @(negedge clk);
    check("t4_clr_xfer_acc", 32'(ifb.out_acc), 32'd2);

    // 16-bit instance
    sync();
    send_c(16'h8001, 2'b01, 4'd15, exp_t'{1'b0, 16'h80, 16'h8001, 16'hC000});
    send_c(16'h1234, 2'b11, 4'd0,  exp_t'{1'b1, 16'h12, 16'h2C48, 16'h3412});
    drain(2, "t6");
    check("t6_acc", 32'(ifc.out_acc), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
